// File: rtl/video_capture.sv
// -----------------------------------------------------------------------------
// video_capture
//
// Pixel-clock-domain capture of a DVI-style RGB stream into framebuffer memory.
// The block recovers pixel coordinates from the DE/VSYNC timing. Each visible
// pixel goes through a small first-word-fall-through FIFO and out of a
// valid/ready write port, so memory backpressure never stalls the video input.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   capture_en      arm capture; looked at only when a frame starts (vsync rise)
//   vid_data/de/h/v incoming pixel, active-video qualifier, syncs
//   fb_wr_addr/data head-of-FIFO write address and pixel
//   fb_wr_valid     FIFO not empty
//   fb_wr_rdy       memory accepts the head entry this cycle
//   frame_done      one-cycle pulse at the end of a captured frame
//   frame_width     DE-high pixel count of the last line of that frame
//   frame_height    number of DE lines in that frame
//   overflow        sticky: a pixel was dropped because the FIFO was full
//   clipped         sticky: a pixel outside the visible window was discarded
//
// Optional build macro VIDEO_CAPTURE_CHECKSUM_EN adds frame_checksum[31:0]. It
// carries a wrapping sum of every in-bounds pixel of the last captured frame.
// -----------------------------------------------------------------------------
module video_capture #(
   parameter int H_VISIBLE_AREA   = 1024,
   parameter int V_VISIBLE_AREA   = 768,
   parameter int RAM_WIDTH        = 24,
   parameter int RAM_ADDR_BITS    = 32,
   parameter logic [RAM_ADDR_BITS-1:0] FB_BASE_ADDR = '0,
   parameter int FIFO_DEPTH       = 16,
   parameter int SYNC_ACTIVE_HIGH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     capture_en,
   input  logic [RAM_WIDTH-1:0]     vid_data,
   input  logic                     vid_de,
   input  logic                     vid_h,
   input  logic                     vid_v,
   output logic [RAM_ADDR_BITS-1:0] fb_wr_addr,
   output logic [RAM_WIDTH-1:0]     fb_wr_data,
   output logic                     fb_wr_valid,
   input  logic                     fb_wr_rdy,
   output logic                     frame_done,
   output logic [15:0]              frame_width,
   output logic [15:0]              frame_height,
   output logic                     overflow,
   output logic                     clipped
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
   ,
   output logic [31:0]              frame_checksum
`endif
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam logic [RAM_ADDR_BITS-1:0] H_VIS    = RAM_ADDR_BITS'(H_VISIBLE_AREA);
   localparam logic [RAM_ADDR_BITS-1:0] V_VIS    = RAM_ADDR_BITS'(V_VISIBLE_AREA);
   localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);
   localparam logic [PTR_BITS-1:0]      PTR_ONE  = PTR_BITS'(1);
   localparam logic [PTR_BITS:0]        CNT_ONE  = (PTR_BITS + 1)'(1);
   localparam logic [PTR_BITS:0]        CNT_FULL = (PTR_BITS + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, VSYNC, CAPTURE} state_t;

   // ---------------------------------------------------------------- input stage
   logic [RAM_WIDTH-1:0] data_reg;
   logic                 de_reg;
   logic                 de_prev;
   logic                 h_reg;
   logic                 v_reg;
   logic                 v_prev;
   logic                 v_rise;
   logic                 v_fall;
   logic                 de_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_reg <= '0;
         de_reg   <= 1'b0;
         de_prev  <= 1'b0;
         h_reg    <= 1'b0;
         v_reg    <= 1'b0;
         v_prev   <= 1'b0;
      end else begin
         data_reg <= vid_data;
         de_reg   <= vid_de;
         de_prev  <= de_reg;
         // Syncs are normalised to active-high here, so the rest of the block
         // does not depend on the source polarity.
         h_reg    <= (SYNC_ACTIVE_HIGH != 0) ? vid_h : ~vid_h;
         v_reg    <= (SYNC_ACTIVE_HIGH != 0) ? vid_v : ~vid_v;
         v_prev   <= v_reg;
      end
   end

   assign v_rise  = v_reg & ~v_prev;
   assign v_fall  = ~v_reg & v_prev;
   assign de_fall = ~de_reg & de_prev;

   // Coordinates come from DE alone. Hsync is registered with the other inputs
   // but has no further use.
   logic unused_hsync;
   assign unused_hsync = h_reg;

   // ---------------------------------------------------------------- coordinates
   state_t                   state;
   logic [RAM_ADDR_BITS-1:0] x;
   logic [RAM_ADDR_BITS-1:0] y;
   logic [RAM_ADDR_BITS-1:0] line_base;   // y * H_VISIBLE_AREA, built by repeated adds
   logic [RAM_ADDR_BITS-1:0] line_width;
   logic                     in_bounds;
   logic                     push_req;
   logic [RAM_ADDR_BITS-1:0] push_addr;

   assign in_bounds = (x < H_VIS) && (y < V_VIS);
   assign push_req  = (state == CAPTURE) && de_reg && in_bounds;
   assign push_addr = FB_BASE_ADDR + line_base + x;

   // ---------------------------------------------------------------- write FIFO
   logic [RAM_ADDR_BITS-1:0] fifo_addr [FIFO_DEPTH];
   logic [RAM_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
   logic [PTR_BITS-1:0]      wr_ptr;
   logic [PTR_BITS-1:0]      rd_ptr;
   logic [PTR_BITS:0]        count;
   logic                     fifo_full;
   logic                     pop;
   logic                     push_ok;

   assign fifo_full   = (count == CNT_FULL);
   assign fb_wr_valid = (count != '0);
   assign pop         = fb_wr_valid & fb_wr_rdy;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
   assign push_ok     = push_req & (~fifo_full | pop);

   // Head entry falls straight through; the idle value is shown while empty.
   assign fb_wr_addr  = fb_wr_valid ? fifo_addr[rd_ptr] : FB_BASE_ADDR;
   assign fb_wr_data  = fb_wr_valid ? fifo_data[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_addr[wr_ptr] <= push_addr;
         fifo_data[wr_ptr] <= data_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (push_req && !push_ok) overflow <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- frame FSM
   function automatic logic [15:0] sat16(input logic [RAM_ADDR_BITS-1:0] v);
      if ((v >> 16) != '0) return 16'hFFFF;
      return v[15:0];
   endfunction

`ifdef VIDEO_CAPTURE_CHECKSUM_EN
   logic [31:0] sum_reg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         x            <= '0;
         y            <= '0;
         line_base    <= '0;
         line_width   <= '0;
         frame_done   <= 1'b0;
         frame_width  <= '0;
         frame_height <= '0;
         clipped      <= 1'b0;
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
         sum_reg        <= '0;
         frame_checksum <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (v_rise && capture_en) state <= VSYNC;
            end
            VSYNC: begin
               if (v_fall) begin
                  state      <= CAPTURE;
                  x          <= '0;
                  y          <= '0;
                  line_base  <= '0;
                  line_width <= '0;
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
                  sum_reg    <= '0;
`endif
               end
            end
            CAPTURE: begin
               if (de_reg) begin
                  // x advances even for clipped or dropped pixels so that
                  // later addresses on the line stay correct.
                  if (!in_bounds) clipped <= 1'b1;
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
                  if (in_bounds) sum_reg <= sum_reg + 32'(data_reg);
`endif
                  x <= x + ADDR_ONE;
               end
               if (de_fall) begin
                  line_width <= x;
                  x          <= '0;
                  y          <= y + ADDR_ONE;
                  line_base  <= line_base + H_VIS;
               end
               if (v_rise) begin
                  frame_done   <= 1'b1;
                  frame_width  <= sat16(line_width);
                  frame_height <= sat16(y);
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
                  frame_checksum <= sum_reg;
`endif
                  state <= capture_en ? VSYNC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
